// File: rtl/wb_master_pkg.sv
// Shared state encoding, command layout and sizing helper for the WISHBONE command bridge.
package wb_master_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [PKG_ADDR_W-3:0]     adr;
        logic [PKG_DATA_W/8-1:0]   sel;
        logic [PKG_DATA_W-1:0]     dat;
    } cmd_t;

    // Width of one queued command {we, word address, byte selects, data}.
    function automatic int cmd_width(input int data_w, input int addr_w);
        return 1 + (addr_w - 2) + data_w / 8 + data_w;
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_cmd_fifo
    import wb_master_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= din;
    end

    // Head entry is visible combinationally so IDLE can pop and load in one edge.
    assign dout = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/wb_master_bridge.sv
// WISHBONE classic-cycle master: queued commands in, one bus cycle each, responses out.
// Optional bus-cycle timeout is built only when WB_TIMEOUT_EN is defined.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-3:0]   cmd_adr_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                rsp_tmo_o,
    output logic [ADDR_W-3:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int AW      = ADDR_W - 2;
    localparam int SW      = DATA_W / 8;
    localparam int ENTRY_W = cmd_width(DATA_W, ADDR_W);

    generate
        if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
            $error("DATA_W must be a non-zero multiple of 8");
        end
        if (ADDR_W < 3) begin : g_bad_addr_w
            $error("ADDR_W must leave at least one word-address bit");
        end
        if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("CMD_DEPTH must be a power of two and at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    state_t             state_reg, state_next;
    logic [AW-1:0]      adr_reg, adr_next;
    logic [DATA_W-1:0]  dat_reg, dat_next;
    logic [SW-1:0]      sel_reg, sel_next;
    logic               we_reg, we_next;
    logic               cyc_reg, cyc_next;
    logic [DATA_W-1:0]  rsp_dat_reg, rsp_dat_next;
    logic               rsp_err_reg, rsp_err_next;

    // Ready is forced low during reset so nothing is accepted into a FIFO being flushed.
    assign cmd_ready_o = !fifo_full && !wb_rst_i;
    assign fifo_din    = {cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i};

    wb_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (wb_clk_i),
        .srst  (wb_rst_i),
        .push  (cmd_valid_i && cmd_ready_o),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;

    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             rsp_tmo_reg, rsp_tmo_next;
    logic             tmo_expired;

    // Counter holds the number of BUS cycles already completed; the last one expires.
    assign tmo_expired = (tmo_cnt_reg == TMO_LAST);
    assign rsp_tmo_o   = rsp_tmo_reg;
`else
    assign rsp_tmo_o   = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        sel_next     = sel_reg;
        we_next      = we_reg;
        cyc_next     = cyc_reg;
        rsp_dat_next = rsp_dat_reg;
        rsp_err_next = rsp_err_reg;
        fifo_pop     = 1'b0;
`ifdef WB_TIMEOUT_EN
        tmo_cnt_next = tmo_cnt_reg;
        rsp_tmo_next = rsp_tmo_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    {we_next, adr_next, sel_next, dat_next} = fifo_dout;
                    cyc_next   = 1'b1;
                    state_next = BUS;
`ifdef WB_TIMEOUT_EN
                    tmo_cnt_next = '0;
                    rsp_tmo_next = 1'b0;
`endif
                end
            end
            BUS: begin
`ifdef WB_TIMEOUT_EN
                tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
`endif
                // Error outranks a simultaneous acknowledge, and both outrank expiry.
                if (cyc_reg && wb_err_i) begin
                    cyc_next     = 1'b0;
                    rsp_err_next = 1'b1;
                    rsp_dat_next = '0;
                    state_next   = RESP;
                end else if (cyc_reg && wb_ack_i) begin
                    cyc_next     = 1'b0;
                    rsp_err_next = 1'b0;
                    rsp_dat_next = we_reg ? '0 : wb_dat_i;
                    state_next   = RESP;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_expired) begin
                    cyc_next     = 1'b0;
                    rsp_err_next = 1'b1;
                    rsp_tmo_next = 1'b1;
                    rsp_dat_next = '0;
                    state_next   = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            adr_reg     <= '0;
            dat_reg     <= '0;
            sel_reg     <= '0;
            we_reg      <= 1'b0;
            cyc_reg     <= 1'b0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_reg <= '0;
            rsp_tmo_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
            sel_reg     <= sel_next;
            we_reg      <= we_next;
            cyc_reg     <= cyc_next;
            rsp_dat_reg <= rsp_dat_next;
            rsp_err_reg <= rsp_err_next;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_reg <= tmo_cnt_next;
            rsp_tmo_reg <= rsp_tmo_next;
`endif
        end
    end

    assign wb_adr_o    = adr_reg;
    assign wb_dat_o    = dat_reg;
    assign wb_sel_o    = sel_reg;
    assign wb_we_o     = we_reg;
    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = cyc_reg;
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_dat_o   = rsp_dat_reg;
    assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge: queue-based command/response model plus a scripted slave.
module tb_wb_master_bridge;
    import wb_master_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int TMO       = 16;
`ifdef WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        cmd_t        cmd;
        int          wt;
        bit          ack;
        bit          err;
        logic [31:0] rdat;
        time         acc_t;
    } item_t;

    typedef struct {
        logic [31:0] dat;
        bit          err;
        bit          tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [9:0]  cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_tmo_o;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    wb_master_bridge #(
        .DATA_W(32), .ADDR_W(12), .CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    item_t       issue_q[$];
    rsp_t        done_q[$];
    item_t       cur;
    rsp_t        cur_rsp;
    int          bus_cnt = 0;
    int          n_acc = 0;
    int          n_started = 0;
    int          n_rsp = 0;
    int          last_bus_len = 0;
    logic [9:0]  last_adr = '0;
    logic [31:0] last_rsp_dat = '0;
    bit          last_rsp_err = 1'b0;
    bit          last_rsp_tmo = 1'b0;
    bit          have_cur = 1'b0;
    bit          ended_prev = 1'b0;
    bit          ended = 1'b0;
    bit          answer = 1'b0;
    bit          tmo_hit = 1'b0;
    bit          mon_off = 1'b1;
    bit          stall = 1'b0;
    bit          rsp_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic item_t mk(input logic we, input logic [9:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat, input int wt, input bit ack,
                                 input bit err, input logic [31:0] rdat);
        item_t it;
        it.cmd.we = we; it.cmd.adr = adr; it.cmd.sel = sel; it.cmd.dat = dat;
        it.wt = wt; it.ack = ack; it.err = err; it.rdat = rdat; it.acc_t = 0;
        return it;
    endfunction

    // Slave, response consumer and scoreboard; runs 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (mon_off) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; rsp_ready_i = 1'b0;
            bus_cnt = 0; ended_prev = 1'b0; rsp_pend = 1'b0; have_cur = 1'b0;
        end else begin
            if (rsp_valid_o) begin
                if (!rsp_pend) begin
                    if (done_q.size() == 0) check("rsp_spurious", 1, 0);
                    else begin cur_rsp = done_q.pop_front(); rsp_pend = 1'b1; end
                end
                if (rsp_pend) begin
                    check("rsp_dat", rsp_dat_o, cur_rsp.dat);
                    check("rsp_err", rsp_err_o, cur_rsp.err);
                    check("rsp_tmo", rsp_tmo_o, cur_rsp.tmo);
                end
                rsp_ready_i = 1'($urandom_range(0, 1));
                if (rsp_ready_i && rsp_pend) begin
                    rsp_pend = 1'b0; n_rsp++;
                    last_rsp_dat = rsp_dat_o; last_rsp_err = rsp_err_o; last_rsp_tmo = rsp_tmo_o;
                end
            end else begin
                rsp_ready_i = 1'($urandom_range(0, 1));
            end

            if (ended_prev) begin
                check("cyc_drop", wb_cyc_o, 0);
                check("rsp_latency", rsp_valid_o, 1);
            end
            ended = 1'b0;
            if (wb_cyc_o && !ended_prev) begin
                if (bus_cnt == 0) begin
                    if (issue_q.size() == 0) begin
                        check("cyc_spurious", 1, 0); have_cur = 1'b0;
                    end else begin
                        cur = issue_q.pop_front(); have_cur = 1'b1; n_started++;
                        check("no_bypass", 64'(($time - cur.acc_t) > 1), 1);
                        check("bus_adr", wb_adr_o, cur.cmd.adr);
                        check("bus_we", wb_we_o, cur.cmd.we);
                        check("bus_sel", wb_sel_o, cur.cmd.sel);
                        check("bus_dat", wb_dat_o, cur.cmd.dat);
                        last_adr = wb_adr_o;
                    end
                end else if (have_cur) begin
                    check("stable_adr", wb_adr_o, cur.cmd.adr);
                    check("stable_dat", wb_dat_o, cur.cmd.dat);
                end
                check("stb", wb_stb_o, 1);
                bus_cnt++;
                answer  = have_cur && !stall && (cur.ack || cur.err) && (bus_cnt > cur.wt);
                tmo_hit = TMO_EN && have_cur && !answer && (bus_cnt == TMO);
                wb_ack_i = answer && cur.ack;
                wb_err_i = answer && cur.err;
                wb_dat_i = answer ? cur.rdat : $urandom;
                if (answer || tmo_hit) begin
                    if (tmo_hit)      done_q.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b1});
                    else if (cur.err) done_q.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
                    else done_q.push_back('{dat: (cur.cmd.we ? 32'h0 : cur.rdat), err: 1'b0, tmo: 1'b0});
                    ended = 1'b1; last_bus_len = bus_cnt; bus_cnt = 0;
                end
            end else begin
                // Noise on ack/err outside a cycle must be ignored by the master.
                bus_cnt  = 0;
                wb_ack_i = 1'($urandom_range(0, 1));
                wb_err_i = 1'($urandom_range(0, 1));
                wb_dat_i = $urandom;
            end
            ended_prev = ended;
            check("cmd_ready", cmd_ready_o, 64'((n_acc - n_started) < CMD_DEPTH));
        end
    end

    task automatic push_cmd(input item_t it);
        int guard = 0;
        @(negedge clk);
        cmd_we_i = it.cmd.we; cmd_adr_i = it.cmd.adr; cmd_sel_i = it.cmd.sel;
        cmd_dat_i = it.cmd.dat; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && guard < 500) begin @(negedge clk); guard++; end
        if (!cmd_ready_o) begin
            check("push_timeout", 0, 1); cmd_valid_i = 1'b0; return;
        end
        @(posedge clk);
        it.acc_t = $time; issue_q.push_back(it); n_acc++;
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (guard < 3000 && !(issue_q.size() == 0 && done_q.size() == 0 && !rsp_pend &&
                                 !wb_cyc_o && !rsp_valid_o)) begin
            @(negedge clk); guard++;
        end
        check("drain", 64'(guard < 3000), 1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        mon_off = 1'b1; wb_rst_i = 1'b1; cmd_valid_i = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_cyc", wb_cyc_o, 0);       check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);         check("rst_adr", wb_adr_o, 0);
        check("rst_wdat", wb_dat_o, 0);      check("rst_sel", wb_sel_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0); check("rst_rsp_dat", rsp_dat_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);  check("rst_rsp_tmo", rsp_tmo_o, 0);
        check("rst_ready_held", cmd_ready_o, 0);
        wb_rst_i = 1'b0;
        issue_q.delete(); done_q.delete(); n_acc = 0; n_started = 0; stall = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready_o, 1);
        mon_off = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        item_t it;
        do_reset(3);

        // Write to byte address 0x040 (word 0x010), zero wait states.
        push_cmd(mk(1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 0, 1'b1, 1'b0, $urandom));
        wait_idle();
        check("t1_adr", last_adr, 10'h010);
        check("t1_len", last_bus_len, 1);
        check("t1_err", last_rsp_err, 0);
        check("t1_dat", last_rsp_dat, 0);

        // Read from byte address 0x044 with three wait states.
        push_cmd(mk(1'b0, 10'h011, 4'hF, 32'h0, 3, 1'b1, 1'b0, 32'h12345678));
        wait_idle();
        check("t2_len", last_bus_len, 4);
        check("t2_dat", last_rsp_dat, 32'h12345678);

        // Stalled slave: one command on the bus plus four queued fills the FIFO.
        base = n_rsp;
        stall = 1'b1;
        for (int i = 0; i < 5; i++)
            push_cmd(mk(1'b1, 10'(32 + i), 4'hF, $urandom, 0, 1'b1, 1'b0, $urandom));
        repeat (3) begin
            @(negedge clk);
            check("t3_full", cmd_ready_o, 0);
        end
        stall = 1'b0;
        push_cmd(mk(1'b0, 10'h025, 4'h3, 32'h0, 1, 1'b1, 1'b0, $urandom));
        wait_idle();
        check("t3_count", n_rsp - base, 6);

        // Error and acknowledge together on a read.
        push_cmd(mk(1'b0, 10'h030, 4'hF, 32'h0, 1, 1'b1, 1'b1, 32'hCAFEF00D));
        wait_idle();
        check("t4_err", last_rsp_err, 1);
        check("t4_dat", last_rsp_dat, 0);
        check("t4_tmo", last_rsp_tmo, 0);

        // Silent slave.
        push_cmd(mk(1'b0, 10'h031, 4'hF, 32'h0, 0, 1'b0, 1'b0, $urandom));
        if (TMO_EN) begin
            wait_idle();
            check("t5_len", last_bus_len, TMO);
            check("t5_err", last_rsp_err, 1);
            check("t5_tmo", last_rsp_tmo, 1);
        end else begin
            repeat (110) @(negedge clk);
            check("t5_hold", wb_cyc_o, 1);
            check("t5_no_rsp", rsp_valid_o, 0);
            do_reset(1);
        end

        // Reset during BUS with two commands queued.
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            push_cmd(mk(1'b1, 10'(64 + i), 4'hF, $urandom, 0, 1'b1, 1'b0, $urandom));
        check("t6_busy", wb_cyc_o, 1);
        do_reset(1);
        repeat (10) @(negedge clk);
        check("t6_idle_cyc", wb_cyc_o, 0);
        check("t6_no_rsp", rsp_valid_o, 0);
        check("t6_ready", cmd_ready_o, 1);

        // Random traffic.
        base = n_rsp;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            it = mk(1'($urandom_range(0, 1)), 10'($urandom), 4'($urandom), $urandom,
                    $urandom_range(0, 3), 1'b1, 1'b0, $urandom);
            if (TMO_EN && $urandom_range(0, 7) == 0) it.wt = $urandom_range(TMO - 2, TMO + 2);
            if (r == 7) begin it.ack = 1'b0; it.err = 1'b1; end
            if (r == 8) it.err = 1'b1;
            if (r == 9 && TMO_EN) it.ack = 1'b0;
            push_cmd(it);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        check("rand_count", n_rsp - base, 40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
